// File: rtl/prime_pkg.sv
// Shared types and widths for the prime sequencer slice.
package prime_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TEST,
    EMIT,
    ADVANCE,
    FIN
  } state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int PROD_WIDTH    = 2 * DEFAULT_WIDTH;

  // Product width for an arbitrary operand width; d*d must never overflow.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/prime_sequencer_if.sv
// Valid/ready stream carrying primes from the sequencer to a consumer.
interface prime_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] prime_out;
  logic             prime_valid;
  logic             prime_ready;

  modport master (output prime_out, output prime_valid, input  prime_ready);
  modport slave  (input  prime_out, input  prime_valid, output prime_ready);
endinterface

// File: rtl/prime_trial_step.sv
// One trial-division step: decides whether d has passed sqrt(cand) and whether d divides cand.
module prime_trial_step
  import prime_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] d,
  output logic             is_prime_done,
  output logic             divides
);

  localparam int PW = prod_width(WIDTH);

  logic [PW-1:0] d_sq;

  assign d_sq          = PW'(d) * PW'(d);
  assign is_prime_done = d_sq > PW'(cand);
  // d is never zero while testing; the guard only keeps the reset state well-defined.
  assign divides       = (d != '0) && ((cand % d) == '0);

endmodule

// File: rtl/prime_sequencer.sv
// Enumerates primes 2..limit by trial division, one divisor per clock, on a valid/ready stream.
// Define PRIME_SKIP_EVEN_EN to skip even candidates and even divisors (same output, fewer cycles).
//
// state   | meaning
// IDLE    | waiting for start, limit captured on accept
// TEST    | trying divisor d against cand
// EMIT    | cand is prime, held on the stream until accepted
// ADVANCE | move to the next candidate or finish
// FIN     | one-cycle done pulse
module prime_sequencer
  import prime_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  prime_sequencer_if.master stream,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  state_t           state;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] d_step;
  logic             is_prime_done;
  logic             divides;

  prime_trial_step #(.WIDTH(WIDTH)) u_step (
    .cand          (cand),
    .d             (d),
    .is_prime_done (is_prime_done),
    .divides       (divides)
  );

`ifdef PRIME_SKIP_EVEN_EN
  logic [WIDTH:0] cand_plus2;
  assign cand_plus2 = {1'b0, cand} + (WIDTH+1)'(2);
  assign d_step     = cand[0] ? WIDTH'(2) : WIDTH'(1);
`else
  assign d_step     = WIDTH'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cand               <= '0;
      d                  <= '0;
      lim                <= '0;
      count              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      stream.prime_valid <= 1'b0;
      stream.prime_out   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            lim   <= limit;
            count <= '0;
            busy  <= 1'b1;
            if (limit < WIDTH'(2)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              cand  <= WIDTH'(2);
              d     <= WIDTH'(2);
              state <= TEST;
            end
          end
        end
        TEST: begin
          if (is_prime_done) begin
            stream.prime_valid <= 1'b1;
            stream.prime_out   <= cand;
            state              <= EMIT;
          end else if (divides) begin
            state <= ADVANCE;
          end else begin
            d <= d + d_step;
          end
        end
        EMIT: begin
          if (stream.prime_ready) begin
            stream.prime_valid <= 1'b0;
            count              <= count + WIDTH'(1);
            state              <= ADVANCE;
          end
        end
        ADVANCE: begin
          // Finishing on cand == lim keeps the candidate from wrapping at the top of the range.
          if (cand == lim) begin
            state <= FIN;
            done  <= 1'b1;
`ifdef PRIME_SKIP_EVEN_EN
          end else if (cand == WIDTH'(2)) begin
            cand  <= WIDTH'(3);
            d     <= WIDTH'(3);
            state <= TEST;
          end else if (cand_plus2 > {1'b0, lim}) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            cand  <= cand_plus2[WIDTH-1:0];
            d     <= WIDTH'(3);
            state <= TEST;
          end
`else
          end else begin
            cand  <= cand + WIDTH'(1);
            d     <= WIDTH'(2);
            state <= TEST;
          end
`endif
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_sequencer.sv
// Directed bench for prime_sequencer: 16-bit and 8-bit instances, expected primes computed here.
module tb_prime_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start16 = 1'b0;
  logic        start8 = 1'b0;
  logic [15:0] limit16 = '0;
  logic [7:0]  limit8 = '0;
  logic        busy16, done16, busy8, done8;
  logic [15:0] count16;
  logic [7:0]  count8;

  int n_checks = 0;
  int n_fail = 0;
  int got[$];
  int done_seen;
  bit timed_out;
  int cycles;

  always #5 clk = ~clk;

  prime_sequencer_if #(.WIDTH(16)) s16 ();
  prime_sequencer_if #(.WIDTH(8))  s8 ();

  prime_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .limit(limit16),
    .stream(s16), .busy(busy16), .done(done16), .count(count16)
  );

  prime_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .limit(limit8),
    .stream(s8), .busy(busy8), .done(done8), .count(count8)
  );

  function automatic bit is_prime_ref(input int n);
    if (n < 2) return 1'b0;
    for (int j = 2; j < n; j++) if (n % j == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start16_run(input int lim);
    start16 = 1'b1;
    limit16 = lim[15:0];
    tick();
    start16 = 1'b0;
  endtask

  // Records every handshake until done (or until stop_after primes); poke_at injects a stray start.
  task automatic collect(input bit w8, input int poke_at, input int stop_after);
    logic        v, rdy, dn;
    logic [15:0] p;
    got.delete();
    done_seen = 0;
    timed_out = 1'b1;
    cycles = 0;
    for (int c = 0; c < 20000; c++) begin
      v   = w8 ? s8.prime_valid : s16.prime_valid;
      rdy = w8 ? s8.prime_ready : s16.prime_ready;
      p   = w8 ? {8'h00, s8.prime_out} : s16.prime_out;
      dn  = w8 ? done8 : done16;
      if (c == poke_at) begin
        start16 = 1'b1;
        limit16 = 16'd5;
      end else begin
        start16 = 1'b0;
      end
      if (v && rdy) got.push_back(int'(p));
      if (dn) begin
        done_seen++;
        timed_out = 1'b0;
        break;
      end
      if (stop_after > 0 && got.size() == stop_after) begin
        timed_out = 1'b0;
        break;
      end
      tick();
      cycles++;
    end
    start16 = 1'b0;
  endtask

  task automatic test_reset();
    s16.prime_ready = 1'b1;
    s8.prime_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (s16.prime_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", s16.prime_valid); end
    n_checks++; if (s16.prime_out !== 16'd0) begin n_fail++; $display("FAIL reset_prime_out: got %0d want 0", s16.prime_out); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy16); end
    n_checks++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done16); end
    n_checks++; if (count16 !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count16); end
  endtask

  task automatic test_limit20();
    int exp_list[8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    start16_run(20);
    n_checks++; if (busy16 !== 1'b1 || s16.prime_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1: busy %b valid %b want 1 0", busy16, s16.prime_valid); end
    tick();
    n_checks++; if (s16.prime_valid !== 1'b1 || s16.prime_out !== 16'd2) begin n_fail++; $display("FAIL lat_cycle2: valid %b out %0d want 1 2", s16.prime_valid, s16.prime_out); end
    collect(1'b0, -1, 0);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL l20_timeout: got no done want done"); end
    n_checks++; if (got.size() != 8) begin n_fail++; $display("FAIL l20_size: got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_checks++; if (got[i] != exp_list[i]) begin n_fail++; $display("FAIL l20_prime[%0d]: got %0d want %0d", i, got[i], exp_list[i]); end
    end
    n_checks++; if (count16 !== 16'd8) begin n_fail++; $display("FAIL l20_count: got %0d want 8", count16); end
    tick();
    n_checks++; if (done16 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("FAIL l20_after_done: done %b busy %b want 0 0", done16, busy16); end
    tick();
    n_checks++; if (count16 !== 16'd8) begin n_fail++; $display("FAIL l20_count_hold: got %0d want 8", count16); end
  endtask

  task automatic test_small_limit();
    int lims[2] = '{1, 0};
    foreach (lims[k]) begin
      start16_run(lims[k]);
      n_checks++; if (done16 !== 1'b1) begin n_fail++; $display("FAIL small%0d_done: got %b want 1", lims[k], done16); end
      n_checks++; if (s16.prime_valid !== 1'b0) begin n_fail++; $display("FAIL small%0d_valid: got %b want 0", lims[k], s16.prime_valid); end
      n_checks++; if (count16 !== 16'd0) begin n_fail++; $display("FAIL small%0d_count: got %0d want 0", lims[k], count16); end
      tick();
      n_checks++; if (done16 !== 1'b0 || busy16 !== 1'b0 || s16.prime_valid !== 1'b0) begin n_fail++; $display("FAIL small%0d_after: done %b busy %b valid %b want 0 0 0", lims[k], done16, busy16, s16.prime_valid); end
    end
  endtask

  task automatic test_backpressure();
    int  first;
    bit  found;
    int  exp_rest[3] = '{3, 5, 7};
    first = -1;
    found = 1'b0;
    s16.prime_ready = 1'b1;
    start16_run(10);
    for (int c = 0; c < 200; c++) begin
      if (s16.prime_valid) begin
        if (s16.prime_out == 16'd3) begin
          found = 1'b1;
          break;
        end
        first = int'(s16.prime_out);
      end
      tick();
    end
    s16.prime_ready = 1'b0;
    n_checks++; if (!found || first != 2) begin n_fail++; $display("FAIL bp_first: got %0d want 2", first); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (s16.prime_valid !== 1'b1 || s16.prime_out !== 16'd3) begin n_fail++; $display("FAIL bp_hold[%0d]: valid %b out %0d want 1 3", i, s16.prime_valid, s16.prime_out); end
    end
    s16.prime_ready = 1'b1;
    collect(1'b0, -1, 0);
    n_checks++; if (timed_out || got.size() != 3) begin n_fail++; $display("FAIL bp_size: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++; if (got[i] != exp_rest[i]) begin n_fail++; $display("FAIL bp_prime[%0d]: got %0d want %0d", i, got[i], exp_rest[i]); end
    end
    n_checks++; if (count16 !== 16'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", count16); end
    tick();
  endtask

  task automatic test_limit97();
    int p;
    start16_run(97);
    collect(1'b0, -1, 0);
    n_checks++; if (timed_out || got.size() != 25) begin n_fail++; $display("FAIL l97_size: got %0d want 25", got.size()); end
    p = 2;
    for (int i = 0; i < got.size(); i++) begin
      n_checks++; if (got[i] != p) begin n_fail++; $display("FAIL l97_prime[%0d]: got %0d want %0d", i, got[i], p); end
      p++;
      while (!is_prime_ref(p)) p++;
    end
    n_checks++; if (got.size() == 0 || got[got.size()-1] != 97) begin n_fail++; $display("FAIL l97_last: got %0d want 97", got.size() ? got[got.size()-1] : -1); end
    n_checks++; if (count16 !== 16'd25) begin n_fail++; $display("FAIL l97_count: got %0d want 25", count16); end
    $display("info: limit 97 run took %0d cycles from first TEST to done", cycles);
    tick();
  endtask

  task automatic test_width8();
    int nprime;
    start8 = 1'b1;
    limit8 = 8'd255;
    tick();
    start8 = 1'b0;
    collect(1'b1, -1, 0);
    n_checks++; if (timed_out || done_seen != 1) begin n_fail++; $display("FAIL w8_done: got %0d want 1", done_seen); end
    n_checks++; if (got.size() != 54) begin n_fail++; $display("FAIL w8_size: got %0d want 54", got.size()); end
    nprime = 0;
    foreach (got[i]) if (is_prime_ref(got[i]) && (i == 0 || got[i] > got[i-1])) nprime++;
    n_checks++; if (nprime != got.size()) begin n_fail++; $display("FAIL w8_order: got %0d good of %0d want all", nprime, got.size()); end
    n_checks++; if (got.size() == 0 || got[got.size()-1] != 251) begin n_fail++; $display("FAIL w8_last: got %0d want 251", got.size() ? got[got.size()-1] : -1); end
    n_checks++; if (count8 !== 8'd54) begin n_fail++; $display("FAIL w8_count: got %0d want 54", count8); end
    tick();
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL w8_busy_after: got %b want 0", busy8); end
  endtask

  task automatic test_restart_and_reset();
    int exp_a[8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    int exp_b[4] = '{2, 3, 5, 7};
    start16_run(20);
    collect(1'b0, 3, 0);
    n_checks++; if (timed_out || got.size() != 8) begin n_fail++; $display("FAIL ign_size: got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_checks++; if (got[i] != exp_a[i]) begin n_fail++; $display("FAIL ign_prime[%0d]: got %0d want %0d", i, got[i], exp_a[i]); end
    end
    n_checks++; if (count16 !== 16'd8) begin n_fail++; $display("FAIL ign_count: got %0d want 8", count16); end
    tick();
    start16_run(97);
    collect(1'b0, -1, 4);
    tick();
    rst_n = 1'b0;
    #2;
    n_checks++; if (s16.prime_valid !== 1'b0 || busy16 !== 1'b0 || count16 !== 16'd0) begin n_fail++; $display("FAIL rst_mid: valid %b busy %b count %0d want 0 0 0", s16.prime_valid, busy16, count16); end
    tick();
    rst_n = 1'b1;
    tick();
    start16_run(10);
    collect(1'b0, -1, 0);
    n_checks++; if (timed_out || got.size() != 4) begin n_fail++; $display("FAIL rst_restart_size: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_checks++; if (got[i] != exp_b[i]) begin n_fail++; $display("FAIL rst_restart_prime[%0d]: got %0d want %0d", i, got[i], exp_b[i]); end
    end
    n_checks++; if (count16 !== 16'd4) begin n_fail++; $display("FAIL rst_restart_count: got %0d want 4", count16); end
    tick();
  endtask

  initial begin
    test_reset();
    test_limit20();
    test_small_limit();
    test_backpressure();
    test_limit97();
    test_width8();
    test_restart_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prime_sequencer.md
Name: prime_sequencer

Overview:
- Sequential generator for the prime-testing side of the library. It enumerates every prime in the range 2..limit in ascending order.
- Primality is decided by iterative trial division, one divisor per clock.
- Each prime is presented on a valid/ready output stream for downstream consumers, e.g. a combinational primality checker used as a scoreboard.

Parameters:
- WIDTH, 16, bit width of limit, candidate, divisor, prime_out and count.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a run. Sampled only in IDLE.
- limit  input  WIDTH  inclusive upper bound. Captured on an accepted start.
- prime_out  output  WIDTH  current prime.
- prime_valid  output  1  prime_out is valid.
- prime_ready  input  1  consumer accepts prime_out.
- busy  output  1  a run is in progress (state is not IDLE).
- done  output  1  one-cycle pulse at the end of a run.
- count  output  WIDTH  number of primes handed off in the current or last run.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Fixed.
- Reset values: all outputs 0, state IDLE, internal candidate/divisor/limit registers 0. Reset asserted mid-run aborts immediately; no partial output is retained.
- States:
  - IDLE: start=1 captures limit. If limit<2, go to FIN. Otherwise set cand=2, d=2, count=0, go to TEST. start while busy is ignored.
  - TEST, with d*d computed at 2*WIDTH bits:
    - If d*d > cand: cand is prime, go to EMIT.
    - Else if cand % d == 0: cand is composite, go to ADVANCE.
    - Else: d <= d+1, stay in TEST.
  - EMIT: prime_valid=1, prime_out=cand. Both are held stable until prime_valid&&prime_ready; on that handshake count increments and the state goes to ADVANCE. prime_valid never drops without a handshake.
  - ADVANCE: if cand == limit, go to FIN (this also covers limit = 2^WIDTH-1, so the candidate never wraps). Otherwise cand <= cand+1, d <= 2, go to TEST.
  - FIN: done=1 for exactly this cycle, then IDLE.
- busy=1 in every state except IDLE.
- count holds its value after FIN until the next accepted start.
- Latency: start accepted at cycle 0 gives TEST at cycle 1 and prime_valid=1 with prime_out=2 at cycle 2.
- limit is inclusive: a prime limit is itself emitted.
- prime_out is registered. There is no combinational path from prime_ready to prime_valid.

Optional Feature:
- Macro: PRIME_SKIP_EVEN_EN.
- Defined:
  - After cand=2, ADVANCE steps cand by 2 (3, 5, 7, ...).
  - For odd cand, d starts at 3 and steps by 2.
  - If cand+2 would exceed limit, ADVANCE goes to FIN instead.
  - The emitted sequence and count are identical to the macro-off case; only cycle counts shrink.
- Undefined: unit steps as described above.

Decomposition:
- Shared package prime_pkg:
  - state enum (IDLE, TEST, EMIT, ADVANCE, FIN);
  - localparam for the product width (2*WIDTH).
- Sub-module prime_trial_step (combinational):
  - inputs cand, d;
  - outputs is_prime_done (d*d > cand) and divides (cand % d == 0).
  - Instantiated once in prime_sequencer.

Test Plan:
- limit=20, prime_ready=1 always -> stream 2,3,5,7,11,13,17,19. count=8, one done pulse, busy low the cycle after done.
- limit=1 (and limit=0) -> prime_valid never asserts, done pulses 1 cycle after start, count=0.
- limit=10, prime_ready held low 5 cycles while prime_out=3 -> prime_out stays 3 and prime_valid stays 1 throughout. Then 5, 7 follow, count=4.
- limit=97 -> last prime 97 emitted (inclusive), count=25. Repeat with PRIME_SKIP_EVEN_EN defined: same sequence, fewer total cycles.
- WIDTH=8, limit=255 -> last prime 251, count=54. No wrap; run terminates with done.
- start pulsed again mid-run is ignored. Then rst_n asserted mid-run -> prime_valid=0, busy=0, count=0 immediately. A new start after reset restarts from 2.
